// File: rtl/p_s_tile_ctrl.sv
// p_s_tile_ctrl
//   Sequencing controller for a LANES-to-serial unpacker. Upstream beats
//   (LANES words each) are written row by row into an external ping-pong
//   LANES x BEATS register tile. A full bank is then read out one word at a
//   time under valid/ready flow control, in beat-major (ORDER=0) or
//   lane-major (ORDER=1) order. One bank fills while the other drains.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid, in_last       upstream beat strobe and end-of-tile marker
//   in_ready                beat accepted this cycle when in_valid is high
//   wr_en, wr_bank, wr_beat buffer write strobe, bank and row
//   rd_en, rd_bank          serial word valid and bank being drained
//   rd_beat, rd_lane        buffer word selected for readout
//   out_ready               downstream consumes the word when rd_en is high
//   out_first, out_last     first / last word of a tile on the serial side
//   err_framing, err_clr    sticky in_last mismatch flag and its clear
//   busy                    any bank full or partial tile in progress
module p_s_tile_ctrl #(
    parameter int LANES = 4,
    parameter int BEATS = 4,
    parameter int ORDER = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic                       wr_en,
    output logic                       wr_bank,
    output logic [$clog2(BEATS)-1:0]   wr_beat,
    output logic                       rd_en,
    output logic                       rd_bank,
    output logic [$clog2(BEATS)-1:0]   rd_beat,
    output logic [$clog2(LANES)-1:0]   rd_lane,
    input  logic                       out_ready,
    output logic                       out_first,
    output logic                       out_last,
    output logic                       err_framing,
    input  logic                       err_clr,
    output logic                       busy
);

    localparam int BW = $clog2(BEATS);
    localparam int LW = $clog2(LANES);
    localparam int N  = LANES * BEATS;
    localparam int KW = $clog2(N);

    localparam logic [BW-1:0] BEAT_MAX = BW'(BEATS - 1);
    localparam logic [KW-1:0] IDX_MAX  = KW'(N - 1);

    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic [BW-1:0] wr_cnt_q, wr_cnt_d;
    logic          rd_bank_q, rd_bank_d;
    logic [KW-1:0] rd_idx_q, rd_idx_d;
    logic          err_q, err_d;

    logic wr_last;
    logic rd_last;
    logic rd_fire;

    // in_ready depends on registers only, so a freed bank shows up one
    // cycle after the drain completes.
    assign in_ready = ~full_q[wr_bank_q];
    assign wr_en    = in_valid & in_ready;
    assign wr_bank  = wr_bank_q;
    assign wr_beat  = wr_cnt_q;

    assign rd_en    = full_q[rd_bank_q];
    assign rd_bank  = rd_bank_q;
    assign rd_fire  = rd_en & out_ready;

    assign wr_last  = (wr_cnt_q == BEAT_MAX);
    assign rd_last  = (rd_idx_q == IDX_MAX);

    assign out_first   = rd_en & (rd_idx_q == '0);
    assign out_last    = rd_en & rd_last;
    assign err_framing = err_q;
    assign busy        = (|full_q) | (wr_cnt_q != '0);

    // Both dimensions are powers of two, so the divide/modulo in the word
    // index mapping reduces to bit slicing of rd_idx.
    generate
        if (ORDER == 0) begin : g_beat_major
            assign rd_beat = rd_idx_q[KW-1:LW];
            assign rd_lane = rd_idx_q[LW-1:0];
        end else begin : g_lane_major
            assign rd_lane = rd_idx_q[KW-1:BW];
            assign rd_beat = rd_idx_q[BW-1:0];
        end
    endgenerate

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        err_d     = err_q;

        if (wr_en) begin
            if (wr_last) begin
                wr_cnt_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + BW'(1);
            end
        end

        // Fill and drain completion never touch the same full bit: a write
        // needs the bank empty, a read needs it full.
        if (rd_fire) begin
            if (rd_last) begin
                rd_idx_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_idx_d = rd_idx_q + KW'(1);
            end
        end

        // wr_cnt stays authoritative on a mismatch; only the flag records it.
        // The set is evaluated last so it wins over a simultaneous clear.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (wr_en && (in_last != wr_last)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_p_s_tile_ctrl.sv
// Testbench for p_s_tile_ctrl (LANES=4, BEATS=4). Instance dut0 uses
// beat-major readout, dut1 lane-major; both see the same stimulus.
module tb_p_s_tile_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0, err_clr = 1'b0;

    logic       in_ready, wr_en, wr_bank, rd_en, rd_bank;
    logic [1:0] wr_beat, rd_beat, rd_lane;
    logic       out_first, out_last, err_framing, busy;

    logic       in_ready_1, wr_en_1, wr_bank_1, rd_en_1, rd_bank_1;
    logic [1:0] wr_beat_1, rd_beat_1, rd_lane_1;
    logic       out_first_1, out_last_1, err_framing_1, busy_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    p_s_tile_ctrl #(.LANES(4), .BEATS(4), .ORDER(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .wr_en(wr_en), .wr_bank(wr_bank), .wr_beat(wr_beat),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_beat(rd_beat), .rd_lane(rd_lane),
        .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
        .err_framing(err_framing), .err_clr(err_clr), .busy(busy)
    );

    p_s_tile_ctrl #(.LANES(4), .BEATS(4), .ORDER(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_1), .wr_en(wr_en_1), .wr_bank(wr_bank_1), .wr_beat(wr_beat_1),
        .rd_en(rd_en_1), .rd_bank(rd_bank_1), .rd_beat(rd_beat_1), .rd_lane(rd_lane_1),
        .out_ready(out_ready), .out_first(out_first_1), .out_last(out_last_1),
        .err_framing(err_framing_1), .err_clr(err_clr), .busy(busy_1)
    );

    typedef struct {
        logic iv, il, ordy, eclr;
        logic e_ir, e_wen, e_wbank;
        int   e_wbeat;
        logic e_ren, e_rbank;
        int   e_rbeat, e_rlane;
        logic e_first, e_last, e_err, e_busy;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic write_tile(input logic ordy);
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1; in_last = (b == 3); out_ready = ordy;
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nacc, words, ncyc, lastt;
        logic exp_ir, exp_rb;

        // Test 1 table: 4 writes into bank 0, 16 beat-major reads, idle.
        for (int i = 0; i < 4; i++)
            vecs[i] = '{1'b1, (i == 3), 1'b1, 1'b0,
                        1'b1, 1'b1, 1'b0, i,
                        1'b0, 1'b0, 0, 0,
                        1'b0, 1'b0, 1'b0, (i != 0)};
        for (int k = 0; k < 16; k++)
            vecs[4+k] = '{1'b0, 1'b0, 1'b1, 1'b0,
                          1'b1, 1'b0, 1'b1, 0,
                          1'b1, 1'b0, k / 4, k % 4,
                          (k == 0), (k == 15), 1'b0, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0,
                     1'b1, 1'b0, 1'b1, 0,
                     1'b0, 1'b1, 0, 0,
                     1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        do_reset();
        #1;
        chk("rst in_ready", in_ready, 1);
        chk("rst rd_en", rd_en, 0);
        chk("rst wr_en", wr_en, 0);
        chk("rst busy", busy, 0);
        chk("rst err", err_framing, 0);
        chk("rst out_first", out_first, 0);
        chk("rst out_last", out_last, 0);
        chk("rst wr_bank", wr_bank, 0);
        chk("rst rd_bank", rd_bank, 0);

        // Test 1
        for (int i = 0; i < 21; i++) begin
            in_valid = vecs[i].iv; in_last = vecs[i].il;
            out_ready = vecs[i].ordy; err_clr = vecs[i].eclr;
            #1;
            chk($sformatf("t1[%0d] in_ready", i), in_ready, vecs[i].e_ir);
            chk($sformatf("t1[%0d] wr_en", i), wr_en, vecs[i].e_wen);
            chk($sformatf("t1[%0d] wr_bank", i), wr_bank, vecs[i].e_wbank);
            chk($sformatf("t1[%0d] wr_beat", i), wr_beat, vecs[i].e_wbeat);
            chk($sformatf("t1[%0d] rd_en", i), rd_en, vecs[i].e_ren);
            chk($sformatf("t1[%0d] rd_bank", i), rd_bank, vecs[i].e_rbank);
            chk($sformatf("t1[%0d] rd_beat", i), rd_beat, vecs[i].e_rbeat);
            chk($sformatf("t1[%0d] rd_lane", i), rd_lane, vecs[i].e_rlane);
            chk($sformatf("t1[%0d] out_first", i), out_first, vecs[i].e_first);
            chk($sformatf("t1[%0d] out_last", i), out_last, vecs[i].e_last);
            chk($sformatf("t1[%0d] err", i), err_framing, vecs[i].e_err);
            chk($sformatf("t1[%0d] busy", i), busy, vecs[i].e_busy);
            step();
        end

        // Test 2: three back-to-back tiles, 48 gapless words
        do_reset();
        nacc = 0; words = 0;
        for (int t = 0; t < 56; t++) begin
            in_valid = (nacc < 12); in_last = ((nacc % 4) == 3); out_ready = 1'b1;
            #1;
            exp_ir = (t < 8) || (t >= 20 && t < 24) || (t >= 36);
            exp_rb = (t >= 20 && t < 36) || (t >= 52);
            chk($sformatf("t2[%0d] in_ready", t), in_ready, exp_ir);
            chk($sformatf("t2[%0d] rd_en", t), rd_en, (t >= 4 && t <= 51));
            chk($sformatf("t2[%0d] rd_bank", t), rd_bank, exp_rb);
            chk($sformatf("t2[%0d] out_first", t), out_first, (t == 4 || t == 20 || t == 36));
            chk($sformatf("t2[%0d] out_last", t), out_last, (t == 19 || t == 35 || t == 51));
            if (in_valid && in_ready) nacc++;
            if (rd_en && out_ready) words++;
            step();
        end
        in_valid = 1'b0;
        chk("t2 beats", nacc, 12);
        chk("t2 words", words, 48);
        chk("t2 err", err_framing, 0);

        // Test 3: backpressure at k=5
        do_reset();
        write_tile(1'b1);
        ncyc = 0; lastt = -1;
        for (int t = 0; t < 24; t++) begin
            out_ready = !(t >= 5 && t <= 7);
            #1;
            if (t >= 5 && t <= 8) begin
                chk($sformatf("t3[%0d] rd_en", t), rd_en, 1);
                chk($sformatf("t3[%0d] rd_beat", t), rd_beat, 1);
                chk($sformatf("t3[%0d] rd_lane", t), rd_lane, 1);
            end
            if (t == 9) begin
                chk("t3 resume beat", rd_beat, 1);
                chk("t3 resume lane", rd_lane, 2);
            end
            if (rd_en) ncyc++;
            if (rd_en && out_ready && out_last) lastt = t;
            step();
        end
        chk("t3 rd cycles", ncyc, 19);
        chk("t3 last cycle", lastt, 18);

        // Test 4: framing error and its clear
        do_reset();
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1; in_last = (b == 2 || b == 3); out_ready = 1'b0;
            #1;
            chk($sformatf("t4[%0d] err", b), err_framing, (b == 3));
            chk($sformatf("t4[%0d] wr_beat", b), wr_beat, b);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0; err_clr = 1'b1;
        #1;
        chk("t4 tile done", rd_en, 1);
        chk("t4 err held", err_framing, 1);
        step();
        err_clr = 1'b0;
        #1;
        chk("t4 err cleared", err_framing, 0);
        in_valid = 1'b1; in_last = 1'b1; err_clr = 1'b1;
        #1;
        chk("t4 coincide wr_en", wr_en, 1);
        chk("t4 coincide wr_bank", wr_bank, 1);
        chk("t4 coincide wr_beat", wr_beat, 0);
        step();
        in_valid = 1'b0; in_last = 1'b0; err_clr = 1'b0;
        #1;
        chk("t4 set wins", err_framing, 1);

        // Test 5: lane-major order on dut1
        do_reset();
        write_tile(1'b1);
        for (int k = 0; k < 16; k++) begin
            #1;
            chk($sformatf("t5[%0d] rd_en", k), rd_en_1, 1);
            chk($sformatf("t5[%0d] rd_beat", k), rd_beat_1, k % 4);
            chk($sformatf("t5[%0d] rd_lane", k), rd_lane_1, k / 4);
            chk($sformatf("t5[%0d] out_first", k), out_first_1, (k == 0));
            chk($sformatf("t5[%0d] out_last", k), out_last_1, (k == 15));
            step();
        end
        #1;
        chk("t5 idle rd_en", rd_en_1, 0);
        chk("t5 idle busy", busy_1, 0);
        chk("t5 rd_bank", rd_bank_1, 1);
        chk("t5 in_ready", in_ready_1, 1);
        chk("t5 wr_bank", wr_bank_1, 1);
        chk("t5 wr_beat", wr_beat_1, 0);
        chk("t5 wr_en", wr_en_1, 0);
        chk("t5 err", err_framing_1, 0);

        // Test 6: async reset mid-drain with bank 1 half-filled
        do_reset();
        write_tile(1'b1);
        for (int t = 0; t < 7; t++) begin
            in_valid = (t < 2); in_last = (t == 0); out_ready = 1'b1;
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("t6 pre rd_en", rd_en, 1);
        chk("t6 pre rd_beat", rd_beat, 1);
        chk("t6 pre rd_lane", rd_lane, 3);
        chk("t6 pre err", err_framing, 1);
        chk("t6 pre wr_beat", wr_beat, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst rd_en", rd_en, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst err", err_framing, 0);
        chk("t6 rst in_ready", in_ready, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_last = 1'b0;
        #1;
        chk("t6 post wr_en", wr_en, 1);
        chk("t6 post wr_bank", wr_bank, 0);
        chk("t6 post wr_beat", wr_beat, 0);
        step();
        in_valid = 1'b0;
        #1;
        chk("t6 post wr_beat next", wr_beat, 1);
        chk("t6 post busy", busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/p_s_tile_ctrl.md
Name: p_s_tile_ctrl

Overview:
- Sequencing controller for the 4-lane-to-serial unpacker datapath.
- Upstream delivers LANES parallel words per beat; BEATS beats form one tile.
- The controller drives write strobes and read selects for an external double-banked LANES x BEATS register tile, then orders the serial readout with valid/ready flow control.
- Ping-pong banking lets one tile fill while the other drains.

Parameters:
- LANES, 4, words per input beat; power of 2, >=2.
- BEATS, 4, beats per tile; power of 2, >=2.
- ORDER, 0, serial order. 0 = beat-major (lane index fastest). 1 = lane-major/transpose (beat index fastest).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream beat available.
- in_last  in  1  upstream marks final beat of tile; checked only.
- in_ready  out  1  controller accepts beat this cycle.
- wr_en  out  1  write current beat into buffer (in_valid & in_ready).
- wr_bank  out  1  bank being filled.
- wr_beat  out  log2(BEATS)  row index of current beat.
- rd_en  out  1  serial word valid; selects buffer word.
- rd_bank  out  1  bank being drained.
- rd_beat  out  log2(BEATS)  beat index of selected word.
- rd_lane  out  log2(LANES)  lane index of selected word.
- out_ready  in  1  downstream consumes word when rd_en=1.
- out_first  out  1  rd_en and word index k==0.
- out_last  out  1  rd_en and k==LANES*BEATS-1.
- err_framing  out  1  sticky in_last mismatch flag.
- err_clr  in  1  synchronous clear of err_framing.
- busy  out  1  any bank full or any beat of a partial tile written.

Behaviour:
- State registers: full[1:0], wr_bank, wr_cnt (beat), rd_bank, rd_idx (k, 0..LANES*BEATS-1), err_framing.
- Reset (async, immediate): full=0, wr_bank=rd_bank=0, wr_cnt=0, rd_idx=0, err_framing=0.
  - Resulting outputs: rd_en/out_first/out_last/wr_en/busy=0, in_ready=1.
  - Reset mid-tile discards all partial and full tiles.
- in_ready = ~full[wr_bank]. It is driven from registers only; no combinational path from in_valid or out_ready.
- Write side:
  - wr_beat = wr_cnt.
  - On wr_en: wr_cnt increments.
  - At wr_cnt==BEATS-1: wr_cnt wraps to 0, full[wr_bank] is set, and wr_bank toggles, all on the same edge.
- Read side:
  - rd_en = full[rd_bank].
  - On rd_en & out_ready: rd_idx increments.
  - At last index: rd_idx wraps to 0, full[rd_bank] clears, and rd_bank toggles.
  - rd_en low or out_ready low: rd_idx, rd_beat and rd_lane hold.
- Index mapping:
  - ORDER=0: rd_beat = k / LANES, rd_lane = k % LANES.
  - ORDER=1: rd_lane = k / BEATS, rd_beat = k % BEATS.
- Latency:
  - rd_en rises the cycle after the edge that accepts the final beat.
  - External data is sampled by the consumer on rd_en & out_ready.
- Simultaneous fill and drain completion on different banks: both take effect on the same edge.
- A bank freed this cycle is not visible to in_ready until the next cycle (one-cycle bubble).
- Set and clear of the same full bit never coincide: write requires not-full, read requires full.
- Steady state:
  - Input accepts BEATS beats per LANES*BEATS output words.
  - in_ready stalls while both banks are full.
- Framing check:
  - On wr_en, if in_last != (wr_cnt==BEATS-1), err_framing sets.
  - wr_cnt stays authoritative; no resync.
  - err_clr clears err_framing; set wins over a simultaneous clear.
- busy = full[0] | full[1] | (wr_cnt != 0).

Test Plan:
1. Reset, 4 consecutive beats with in_last on the 4th, out_ready=1.
   - wr_beat 0,1,2,3 on bank 0.
   - rd_en high the next cycle for 16 cycles, in order (beat,lane) = (0,0),(0,1),(0,2),(0,3),(1,0)...(3,3).
   - out_first on the 1st word, out_last on the 16th; then rd_bank=1 and busy=0.
2. Three tiles, in_valid held high, out_ready=1.
   - Tile 1 fills bank 1 during drain of bank 0.
   - Tile 2: in_ready=0 until one cycle after bank 0's out_last, then fills bank 0.
   - 48 words out with no gaps.
3. Backpressure: out_ready=0 for 3 cycles at k=5 (ORDER=0).
   - rd_beat=1, rd_lane=1 held with rd_en=1.
   - Resumes at k=6; total 19 cycles for the tile.
4. Framing error: in_last on beat 2 of a tile.
   - err_framing=1 after that edge; the tile still completes at beat 3.
   - err_clr alone clears it.
   - err_clr coincident with a new mismatch leaves it at 1.
5. ORDER=1, single tile.
   - Sequence (beat,lane) = (0,0),(1,0),(2,0),(3,0),(0,1)...(3,3).
6. rst_n low asynchronously at k=7 with bank 1 half-filled.
   - Outputs drop immediately: rd_en=0, busy=0, err_framing=0.
   - After release, in_ready=1 and the next tile writes bank 0 at beat 0.
